// File: rtl/rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback
// Description : Regfile write-side: ALU/LSU arbitration (LSU priority), load
//               formatting, registered write port and RAW busy scoreboard.
//               Optional RF_WB_FWD_EN adds write-port forwarding hit outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid_i,
    input  logic [4:0]              issue_rd_i,
    input  logic                    alu_valid_i,
    output logic                    alu_ready_o,
    input  logic [4:0]              alu_rd_i,
    input  logic [DATA_WIDTH-1:0]   alu_data_i,
    input  logic                    lsu_valid_i,
    output logic                    lsu_ready_o,
    input  logic [4:0]              lsu_rd_i,
    input  logic [DATA_WIDTH-1:0]   lsu_data_i,
    input  logic [1:0]              lsu_size_i,
    input  logic                    lsu_unsigned_i,
    input  logic [1:0]              lsu_off_i,
    output logic                    wen_o,
    output logic [4:0]              rd_o,
    output logic [DATA_WIDTH-1:0]   wdata_o,
    output logic [DATA_WIDTH/8-1:0] wstrb_o,
    input  logic [4:0]              rs1_i,
    input  logic [4:0]              rs2_i,
    output logic                    rs1_busy_o,
    output logic                    rs2_busy_o,
    output logic                    misalign_o
`ifdef RF_WB_FWD_EN
    ,
    output logic                    fwd1_hit_o,
    output logic                    fwd2_hit_o,
    output logic [DATA_WIDTH-1:0]   fwd_data_o
`endif
);

    localparam int         c_rd_w      = 5;
    localparam int         c_strb_w    = DATA_WIDTH / 8;
    localparam logic [1:0] c_size_byte = 2'b00;
    localparam logic [1:0] c_size_half = 2'b01;
    localparam logic [1:0] c_size_word = 2'b10;

    logic                  w_lsu_xfer;
    logic                  w_alu_xfer;
    logic                  w_xfer;
    logic [c_rd_w-1:0]     w_xfer_rd;
    logic [DATA_WIDTH-1:0] w_xfer_data;
    logic                  w_xfer_mis;
    logic                  w_xfer_write;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_misalign;
    logic [DATA_WIDTH-1:0] w_fmt_data;
    logic [N_REGS-1:0]     w_busy_set;
    logic [N_REGS-1:0]     w_busy_clr;
    logic                  w_rs1_sb;
    logic                  w_rs2_sb;

    logic                  r_wen;
    logic [c_rd_w-1:0]     r_rd;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_misalign;
    logic [N_REGS-1:0]     r_busy;

    // Readies are gated by rst_n so nothing handshakes while held in reset.
    assign lsu_ready_o = rst_n;
    assign alu_ready_o = rst_n & ~lsu_valid_i;

    assign w_lsu_xfer = lsu_valid_i & lsu_ready_o;
    assign w_alu_xfer = alu_valid_i & alu_ready_o;
    assign w_xfer     = w_lsu_xfer | w_alu_xfer;

    always_comb begin
        w_byte     = lsu_data_i[{lsu_off_i, 3'b000} +: 8];
        w_half     = lsu_data_i[{lsu_off_i[1], 4'b0000} +: 16];
        w_misalign = 1'b0;
        w_fmt_data = lsu_data_i;
        case (lsu_size_i)
            c_size_byte: begin
                w_fmt_data = {{(DATA_WIDTH-8){w_byte[7] & ~lsu_unsigned_i}}, w_byte};
            end
            c_size_half: begin
                w_misalign = lsu_off_i[0];
                w_fmt_data = {{(DATA_WIDTH-16){w_half[15] & ~lsu_unsigned_i}}, w_half};
            end
            c_size_word: begin
                w_misalign = (lsu_off_i != 2'b00);
            end
            default: begin
                w_misalign = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_xfer_rd    = lsu_valid_i ? lsu_rd_i   : alu_rd_i;
        w_xfer_data  = lsu_valid_i ? w_fmt_data : alu_data_i;
        w_xfer_mis   = w_lsu_xfer & w_misalign;
        w_xfer_write = w_xfer & ~w_xfer_mis & (w_xfer_rd != '0);
    end

    // rd/wdata only move on a real write so the regfile port holds its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wen      <= 1'b0;
            r_rd       <= '0;
            r_wdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_wen      <= w_xfer_write;
            r_misalign <= w_xfer_mis;
            if (w_xfer_write) begin
                r_rd    <= w_xfer_rd;
                r_wdata <= w_xfer_data;
            end
        end
    end

    assign wen_o      = r_wen;
    assign rd_o       = r_rd;
    assign wdata_o    = r_wdata;
    assign wstrb_o    = {c_strb_w{r_wen}};
    assign misalign_o = r_misalign;

    for (genvar g = 0; g < N_REGS; g++) begin : g_busy
        if (g == 0) begin : g_x0
            assign w_busy_set[g] = 1'b0;
            assign w_busy_clr[g] = 1'b0;
        end else begin : g_xn
            assign w_busy_set[g] = issue_valid_i & (issue_rd_i == c_rd_w'(g));
            // Misaligned/illegal loads still retire their destination.
            assign w_busy_clr[g] = w_xfer & (w_xfer_rd == c_rd_w'(g));
        end
    end

    // Set after clear: a same-cycle issue belongs to a younger producer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_busy_clr) | w_busy_set;
        end
    end

    assign w_rs1_sb = (rs1_i != '0) & r_busy[rs1_i];
    assign w_rs2_sb = (rs2_i != '0) & r_busy[rs2_i];

`ifdef RF_WB_FWD_EN
    assign fwd1_hit_o = r_wen & (r_rd == rs1_i) & (rs1_i != '0);
    assign fwd2_hit_o = r_wen & (r_rd == rs2_i) & (rs2_i != '0);
    assign fwd_data_o = r_wdata;
    assign rs1_busy_o = w_rs1_sb & ~fwd1_hit_o;
    assign rs2_busy_o = w_rs2_sb & ~fwd2_hit_o;
`else
    assign rs1_busy_o = w_rs1_sb;
    assign rs2_busy_o = w_rs2_sb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_writeback
// Description : Randomized + directed self-checking bench for rf_writeback
//               (default build, RF_WB_FWD_EN undefined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid_i;
    logic [4:0]  issue_rd_i;
    logic        alu_valid_i;
    logic        alu_ready_o;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_unsigned_i;
    logic [1:0]  lsu_off_i;
    logic        wen_o;
    logic [4:0]  rd_o;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic        misalign_o;

    rf_writeback #(.DATA_WIDTH(32), .N_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
        .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
        .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_size_i(lsu_size_i), .lsu_unsigned_i(lsu_unsigned_i),
        .lsu_off_i(lsu_off_i),
        .wen_o(wen_o), .rd_o(rd_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
        .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
        .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: which registers have a pending writer, and what the
    // write port last wrote.
    bit          busy_m [32];
    logic [4:0]  last_rd;
    logic [31:0] last_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic bit misal_m(input logic [1:0] sz, input logic [1:0] off);
        return (sz == 2'd3) || (sz == 2'd2 && off != 2'd0) || (sz == 2'd1 && off[0]);
    endfunction

    function automatic logic [31:0] fmt_m(input logic [31:0] d, input logic [1:0] sz,
                                          input logic u, input logic [1:0] off);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (d >> (int'(off) * 8)) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (d >> (int'(off[1]) * 16)) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = d;
        end
        return v;
    endfunction

    task automatic model_reset();
        foreach (busy_m[r]) busy_m[r] = 1'b0;
        last_rd   = '0;
        last_data = '0;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        alu_valid_i   = 1'b0;
        lsu_valid_i   = 1'b0;
    endtask

    // One cycle: inputs already driven; checks combinational outputs, then the
    // registered outputs produced by this cycle's transfer.
    task automatic step();
        bit          xfer, nwen, nmis, iss;
        logic [4:0]  xrd, ird;
        logic [31:0] v;
        #1;
        chk("lsu_ready", lsu_ready_o, 1);
        chk("alu_ready", alu_ready_o, !lsu_valid_i);
        chk("rs1_busy", rs1_busy_o, (rs1_i != 0) && busy_m[rs1_i]);
        chk("rs2_busy", rs2_busy_o, (rs2_i != 0) && busy_m[rs2_i]);
        xfer = 0; nwen = 0; nmis = 0; xrd = 0; v = 0;
        if (lsu_valid_i) begin
            xfer = 1;
            xrd  = lsu_rd_i;
            nmis = misal_m(lsu_size_i, lsu_off_i);
            v    = fmt_m(lsu_data_i, lsu_size_i, lsu_unsigned_i, lsu_off_i);
            nwen = !nmis && xrd != 0;
        end else if (alu_valid_i) begin
            xfer = 1;
            xrd  = alu_rd_i;
            v    = alu_data_i;
            nwen = xrd != 0;
        end
        iss = issue_valid_i;
        ird = issue_rd_i;
        @(posedge clk);
        if (xfer && xrd != 0) busy_m[xrd] = 1'b0;
        if (iss && ird != 0)  busy_m[ird] = 1'b1;
        if (nwen) begin
            last_rd   = xrd;
            last_data = v;
        end
        @(negedge clk);
        chk("wen", wen_o, nwen);
        chk("misalign", misalign_o, nmis);
        chk("wstrb", wstrb_o, nwen ? 4'hF : 4'h0);
        chk("rd", rd_o, last_rd);
        chk("wdata", wdata_o, last_data);
    endtask

    task automatic lsu_load(input logic [4:0] rd, input logic [31:0] d, input logic [1:0] sz,
                            input logic u, input logic [1:0] off);
        lsu_valid_i = 1; lsu_rd_i = rd; lsu_data_i = d;
        lsu_size_i = sz; lsu_unsigned_i = u; lsu_off_i = off;
    endtask

    initial begin
        rst_n = 0;
        idle();
        issue_rd_i = 0; alu_rd_i = 0; alu_data_i = 0;
        lsu_rd_i = 0; lsu_data_i = 0; lsu_size_i = 0; lsu_unsigned_i = 0; lsu_off_i = 0;
        rs1_i = 0; rs2_i = 0;
        model_reset();

        // Model pinned against hand-computed load formats.
        chk("m_b3s", fmt_m(32'h80FF_7F01, 2'd0, 1'b0, 2'd3), 32'hFFFF_FF80);
        chk("m_b3u", fmt_m(32'h80FF_7F01, 2'd0, 1'b1, 2'd3), 32'h0000_0080);
        chk("m_h2s", fmt_m(32'h80FF_7F01, 2'd1, 1'b0, 2'd2), 32'hFFFF_80FF);
        chk("m_h1", misal_m(2'd1, 2'd1), 1);

        #1;
        chk("rst_wen", wen_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_wdata", wdata_o, 0);
        chk("rst_wstrb", wstrb_o, 0);
        chk("rst_mis", misalign_o, 0);
        chk("rst_lsu_rdy", lsu_ready_o, 0);
        chk("rst_alu_rdy", alu_ready_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // ALU single write.
        alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234_5678;
        step();
        chk("t1_wen", wen_o, 1);
        chk("t1_rd", rd_o, 5);
        chk("t1_wdata", wdata_o, 32'h1234_5678);
        chk("t1_wstrb", wstrb_o, 4'hF);
        idle();
        step();
        chk("t1_wen_off", wen_o, 0);
        chk("t1_hold", wdata_o, 32'h1234_5678);

        // LSU priority over ALU; stalled ALU holds its inputs.
        alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'h3333_0003;
        lsu_load(5'd4, 32'hDEAD_BEEF, 2'd2, 1'b0, 2'd0);
        #1;
        chk("t2_lsu_rdy", lsu_ready_o, 1);
        chk("t2_alu_rdy", alu_ready_o, 0);
        step();
        chk("t2_x4", wdata_o, 32'hDEAD_BEEF);
        lsu_valid_i = 0;
        step();
        chk("t2_x3_rd", rd_o, 3);
        idle();

        // Load formatting.
        lsu_load(5'd10, 32'h80FF_7F01, 2'd0, 1'b0, 2'd3); step();
        chk("t3_b3s", wdata_o, 32'hFFFF_FF80);
        lsu_load(5'd10, 32'h80FF_7F01, 2'd0, 1'b1, 2'd3); step();
        chk("t3_b3u", wdata_o, 32'h0000_0080);
        lsu_load(5'd10, 32'h80FF_7F01, 2'd1, 1'b0, 2'd2); step();
        chk("t3_h2s", wdata_o, 32'hFFFF_80FF);
        lsu_load(5'd10, 32'h80FF_7F01, 2'd1, 1'b0, 2'd1); step();
        chk("t3_h1_mis", misalign_o, 1);
        chk("t3_h1_wen", wen_o, 0);
        idle(); step();
        chk("t3_mis_pulse", misalign_o, 0);

        // Scoreboard: issue x7, then retire it with a load.
        issue_valid_i = 1; issue_rd_i = 7; step();
        idle(); rs1_i = 7; rs2_i = 0;
        #1;
        chk("t4_busy", rs1_busy_o, 1);
        chk("t4_rs2_0", rs2_busy_o, 0);
        step();
        lsu_load(5'd7, 32'h0000_0077, 2'd2, 1'b0, 2'd0); step();
        idle();
        #1;
        chk("t4_free", rs1_busy_o, 0);
        step();

        // Same-cycle issue and retire of x9: stays busy.
        issue_valid_i = 1; issue_rd_i = 9; step();
        alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h9;
        rs1_i = 9; step();
        idle();
        #1;
        chk("t5_busy9", rs1_busy_o, 1);
        alu_valid_i = 1; alu_rd_i = 9; alu_data_i = 32'h99; step();
        idle();
        #1;
        chk("t5_free9", rs1_busy_o, 0);

        // Randomized traffic; a stalled ALU request is held unchanged.
        for (int n = 0; n < 600; n++) begin
            if (!(alu_valid_i && lsu_valid_i)) begin
                alu_valid_i = 1'($urandom_range(0, 1));
                alu_rd_i    = 5'($urandom_range(0, 7));
                alu_data_i  = $urandom;
            end
            lsu_valid_i    = ($urandom_range(0, 2) == 0);
            lsu_rd_i       = 5'($urandom_range(0, 7));
            lsu_data_i     = $urandom;
            lsu_size_i     = 2'($urandom_range(0, 3));
            lsu_unsigned_i = 1'($urandom_range(0, 1));
            lsu_off_i      = 2'($urandom_range(0, 3));
            issue_valid_i  = ($urandom_range(0, 2) == 0);
            issue_rd_i     = 5'($urandom_range(0, 7));
            rs1_i          = 5'($urandom_range(0, 7));
            rs2_i          = 5'($urandom_range(0, 31));
            step();
        end

        // Mid-operation reset while a write is on the port.
        issue_valid_i = 1; issue_rd_i = 12;
        alu_valid_i = 1; alu_rd_i = 6; alu_data_i = 32'hCAFE_0006; lsu_valid_i = 0;
        step();
        chk("t6_pre_wen", wen_o, 1);
        rst_n = 0;
        #1;
        chk("t6_wen", wen_o, 0);
        chk("t6_wdata", wdata_o, 0);
        chk("t6_wstrb", wstrb_o, 0);
        model_reset();
        for (int r = 1; r < 32; r++) begin
            rs1_i = 5'(r);
            #0.1;
            chk("t6_busy_clr", rs1_busy_o, 0);
        end
        idle();
        @(negedge clk);
        rst_n = 1;
        rs1_i = 12; rs2_i = 0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
